// File: rtl/hdbn_pkg.sv
// Shared types and constants for the HDBn / AMI line encoder.
package hdbn_pkg;

   // Symbol type carried through the delay line and onto out_code.
   typedef enum logic [1:0] {
      ZERO   = 2'b00,
      MARK   = 2'b01,
      BPULSE = 2'b10,
      VPULSE = 2'b11
   } sym_t;

   // Dual-rail ternary encodings as {p, n}.
   localparam logic [1:0] RAIL_ZERO = 2'b00;
   localparam logic [1:0] RAIL_POS  = 2'b10;
   localparam logic [1:0] RAIL_NEG  = 2'b01;

   // Map a pulse polarity (1 = positive) onto the dual-rail pair.
   function automatic logic [1:0] rail_of(input logic pol);
      return pol ? RAIL_POS : RAIL_NEG;
   endfunction

endpackage

// File: rtl/hdbn_polar_stage.sv
// Output polarity stage: turns a symbol type into a dual-rail pulse,
// tracking the polarity of the last non-zero pulse.
module hdbn_polar_stage
   import hdbn_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_en,
   input  sym_t       i_sym,
   output logic       o_p,
   output logic       o_n,
   output logic [1:0] o_code
);

   logic       r_last_pol;   // 1 = last pulse positive, 0 = negative
   logic [1:0] r_rail;
   sym_t       r_code;

   logic       w_flip;
   logic       w_pol;
   logic [1:0] w_rail;

   // Marks and B pulses alternate polarity; V repeats the last polarity.
   always_comb begin
      w_flip = (i_sym == MARK) || (i_sym == BPULSE);
      w_pol  = w_flip ? ~r_last_pol : r_last_pol;
      w_rail = (i_sym == ZERO) ? RAIL_ZERO : rail_of(w_pol);
   end

   // Register the emitted pulse and polarity history; hold when not enabled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_pol <= 1'b0;
         r_rail     <= RAIL_ZERO;
         r_code     <= ZERO;
      end else if (i_en) begin
         r_last_pol <= w_pol;
         r_rail     <= w_rail;
         r_code     <= i_sym;
      end
   end

   assign o_p    = r_rail[1];
   assign o_n    = r_rail[0];
   assign o_code = r_code;

endmodule

// File: rtl/hdbn_line_encoder.sv
// HDBn / AMI line encoder: NRZ bits in, dual-rail ternary symbols out,
// with ZRUN accepted bits of latency so zero runs can be rewritten in place.
module hdbn_line_encoder
   import hdbn_pkg::*;
#(
   parameter int unsigned ZRUN     = 4,
   parameter bit          DEF_MODE = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in_valid,
   input  logic       in_bit,
   input  logic       mode,
   output logic       out_valid,
   output logic       out_p,
   output logic       out_n,
   output logic [1:0] out_code
);

   localparam int unsigned CW = $clog2(ZRUN + 1);
   localparam logic [CW-1:0] C_ZRUN    = CW'(ZRUN);
   localparam logic [CW-1:0] C_ZRUN_M1 = CW'(ZRUN - 1);

   // r_dl[0] is the newest symbol, r_dl[ZRUN-1] the next one to leave.
   sym_t          r_dl      [ZRUN];
   sym_t          w_dl_next [ZRUN];

   logic [CW-1:0] r_zcnt;
   logic [CW-1:0] r_fill;
   logic          r_parity;
   logic          r_mode;
   logic          r_out_valid;

   logic [CW-1:0] w_zbase;
   logic [CW-1:0] w_zcnt_next;
   logic          w_parity_next;
   logic          w_subst;
   logic          w_fill_full;
   logic          w_emit;

   // Next delay-line contents, zero-run count and parity for the incoming bit.
   always_comb begin
      // A mode change restarts the zero-run count with this bit.
      w_zbase     = (mode != r_mode) ? '0 : r_zcnt;
      w_subst     = mode && !in_bit && (w_zbase == C_ZRUN_M1);

      w_zcnt_next = w_zbase;
      if (in_bit || w_subst) begin
         w_zcnt_next = '0;
      end else if (w_zbase != C_ZRUN) begin
         w_zcnt_next = w_zbase + 1'b1;
      end

      w_parity_next = w_subst ? 1'b0 : (r_parity ^ in_bit);

      w_dl_next[0] = in_bit ? MARK : ZERO;
      for (int unsigned i = 1; i < ZRUN; i++) begin
         w_dl_next[i] = r_dl[i-1];
      end

      // The run being replaced is exactly ZRUN long, so after the shift it
      // fills the whole delay line: oldest zero at ZRUN-1, this bit at 0.
      if (w_subst) begin
         for (int unsigned i = 0; i < ZRUN; i++) begin
            w_dl_next[i] = ZERO;
         end
         w_dl_next[0] = VPULSE;
         if (!r_parity) begin
            w_dl_next[ZRUN-1] = BPULSE;
         end
      end

      w_fill_full = (r_fill == C_ZRUN);
      w_emit      = in_valid && w_fill_full;
   end

   // Input-side state advances only on accepted bits.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < ZRUN; i++) begin
            r_dl[i] <= ZERO;
         end
         r_zcnt   <= '0;
         r_fill   <= '0;
         r_parity <= 1'b0;
         r_mode   <= DEF_MODE;
      end else if (in_valid) begin
         for (int unsigned i = 0; i < ZRUN; i++) begin
            r_dl[i] <= w_dl_next[i];
         end
         r_zcnt   <= w_zcnt_next;
         r_parity <= w_parity_next;
         r_mode   <= mode;
         if (!w_fill_full) begin
            r_fill <= r_fill + 1'b1;
         end
      end
   end

   // One-cycle strobe for each symbol leaving a full delay line.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= w_emit;
      end
   end

   hdbn_polar_stage u_polar (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en    (w_emit),
      .i_sym   (r_dl[ZRUN-1]),
      .o_p     (out_p),
      .o_n     (out_n),
      .o_code  (out_code)
   );

   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_hdbn_line_encoder.sv
// Self-checking bench for hdbn_line_encoder (ZRUN=4 and ZRUN=3 instances).
module tb_hdbn_line_encoder;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       iv4 = 1'b0, ib4 = 1'b0, md4 = 1'b1;
   logic       iv3 = 1'b0, ib3 = 1'b0, md3 = 1'b1;
   logic       ov4, p4, n4;
   logic       ov3, p3, n3;
   logic [1:0] c4, c3;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hdbn_line_encoder #(.ZRUN(4), .DEF_MODE(1'b1)) dut4 (
      .clk(clk), .reset_n(reset_n), .in_valid(iv4), .in_bit(ib4), .mode(md4),
      .out_valid(ov4), .out_p(p4), .out_n(n4), .out_code(c4));

   hdbn_line_encoder #(.ZRUN(3), .DEF_MODE(1'b1)) dut3 (
      .clk(clk), .reset_n(reset_n), .in_valid(iv3), .in_bit(ib3), .mode(md3),
      .out_valid(ov3), .out_p(p3), .out_n(n3), .out_code(c3));

   // Expected {out_valid, out_p, out_n, out_code}
   localparam logic [4:0] Z0  = 5'b0_00_00;
   localparam logic [4:0] VZ  = 5'b1_00_00;
   localparam logic [4:0] VPM = 5'b1_10_01;
   localparam logic [4:0] VNM = 5'b1_01_01;
   localparam logic [4:0] VPB = 5'b1_10_10;
   localparam logic [4:0] VNB = 5'b1_01_10;
   localparam logic [4:0] VPV = 5'b1_10_11;
   localparam logic [4:0] VNV = 5'b1_01_11;
   localparam logic [4:0] HPM = 5'b0_10_01;
   localparam logic [4:0] HNM = 5'b0_01_01;

   typedef struct {
      bit         sel;   // 0 = ZRUN 4 instance, 1 = ZRUN 3 instance
      bit         rst;
      bit         vld;
      bit         din;
      bit         md;
      logic [4:0] exp;
   } vec_t;

   vec_t       tbl[$];
   bit         q_bits[$];
   bit         q_modes[$];
   logic [3:0] q_exp[$];
   bit         q_cv[$];
   logic [4:0] q_co[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   function automatic logic [4:0] obs(input bit sel);
      return sel ? {ov3, p3, n3, c3} : {ov4, p4, n4, c4};
   endfunction

   task automatic row(input bit sel, input bit rst, input bit vld, input bit din,
                      input bit md, input logic [4:0] exp);
      vec_t v;
      v.sel = sel; v.rst = rst; v.vld = vld; v.din = din; v.md = md; v.exp = exp;
      tbl.push_back(v);
   endtask

   task automatic acc(input bit sel, input bit din, input bit md, input logic [4:0] exp);
      row(sel, 1'b0, 1'b1, din, md, exp);
   endtask

   task automatic drive(input bit sel, input bit vld, input bit din, input bit md);
      if (sel) begin
         iv3 = vld; ib3 = din; md3 = md; iv4 = 1'b0;
      end else begin
         iv4 = vld; ib4 = din; md4 = md; iv3 = 1'b0;
      end
   endtask

   task automatic apply(input int idx, input vec_t v);
      if (v.rst) begin
         @(negedge clk);
         iv4 = 1'b0; iv3 = 1'b0;
         reset_n = 1'b0;
         #1 chk($sformatf("row %0d reset", idx), 32'(obs(v.sel)), 32'(v.exp));
         @(negedge clk);
         reset_n = 1'b1;
      end else begin
         @(negedge clk);
         drive(v.sel, v.vld, v.din, v.md);
         @(posedge clk);
         #1 chk($sformatf("row %0d", idx), 32'(obs(v.sel)), 32'(v.exp));
      end
   endtask

   // Reference: build the symbol sequence from the encoding rules, then
   // assign polarities by scanning it.
   task automatic model(input int z);
      int s[$];
      int run;
      bit par, pm, lp;
      s = {}; q_exp = {};
      run = 0; par = 1'b0; pm = 1'b1; lp = 1'b0;
      foreach (q_bits[i]) begin
         if (q_modes[i] != pm) run = 0;
         pm = q_modes[i];
         if (q_bits[i]) begin
            s.push_back(1); run = 0; par = ~par;
         end else begin
            s.push_back(0); run++;
            if (pm && run == z) begin
               if (!par) s[s.size()-z] = 2;
               s[s.size()-1] = 3;
               par = 1'b0; run = 0;
            end
         end
      end
      foreach (s[i]) begin
         case (s[i])
            0:       q_exp.push_back(4'b0000);
            1, 2: begin
               lp = ~lp;
               q_exp.push_back({lp, ~lp, 2'(s[i])});
            end
            default: q_exp.push_back({lp, ~lp, 2'b11});
         endcase
      end
   endtask

   task automatic run_stream(input bit sel, input int nbits, input bit mix, input int z,
                             input string name);
      int         nacc, k, zrun, maxrun, nv, viol;
      bit         v, b, m, eov, have_v, last_vpol;
      logic [3:0] held;
      @(negedge clk);
      iv4 = 1'b0; iv3 = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      q_bits = {}; q_modes = {}; q_cv = {}; q_co = {};
      m = 1'b1; nacc = 0;
      for (int c = 0; c < nbits * 10 && nacc < nbits; c++) begin
         @(negedge clk);
         v = ($urandom_range(0, 3) != 0);
         b = ($urandom_range(0, 9) < 4);
         if (mix && v && $urandom_range(0, 39) == 0) m = ~m;
         drive(sel, v, b, m);
         if (v) begin
            q_bits.push_back(b); q_modes.push_back(m); nacc++;
         end
         @(posedge clk);
         #1;
         q_cv.push_back(v);
         q_co.push_back(obs(sel));
      end
      @(negedge clk);
      iv4 = 1'b0; iv3 = 1'b0;
      chk({name, " accepted count"}, nacc, nbits);

      model(z);
      k = 0; nacc = 0; held = 4'b0000;
      for (int j = 0; j < q_cv.size(); j++) begin
         eov = q_cv[j] && (nacc >= z);
         if (eov) begin
            if (k < q_exp.size()) held = q_exp[k];
            k++;
         end
         chk({name, " cycle"}, 32'(q_co[j]), 32'({eov, held}));
         chk({name, " rail exclusive"}, 32'(q_co[j][3] & q_co[j][2]), 0);
         if (q_cv[j]) nacc++;
      end

      if (sel) begin
         zrun = 0; maxrun = 0; nv = 0; viol = 0; have_v = 1'b0; last_vpol = 1'b0;
         foreach (q_co[j]) begin
            if (q_co[j][4]) begin
               if (q_co[j][3:2] == 2'b00) begin
                  zrun++;
                  if (zrun > maxrun) maxrun = zrun;
               end else begin
                  zrun = 0;
               end
               if (q_co[j][1:0] == 2'b11) begin
                  nv++;
                  if (have_v && q_co[j][3] == last_vpol) viol++;
                  have_v = 1'b1;
                  last_vpol = q_co[j][3];
               end
            end
         end
         chk({name, " no four-zero run"}, 32'(maxrun < 4), 1);
         chk({name, " V seen"}, 32'(nv > 0), 1);
         chk({name, " V alternation violations"}, viol, 0);
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: run exceeded time limit (compared %0d)", n_cmp);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // 1,0000 in HDBn: odd parity gives 000V
      row(0, 1, 0, 0, 1, Z0);
      acc(0, 1, 1, Z0); acc(0, 0, 1, Z0); acc(0, 0, 1, Z0); acc(0, 0, 1, Z0);
      acc(0, 0, 1, VPM);
      acc(0, 1, 1, VZ); acc(0, 1, 1, VZ); acc(0, 1, 1, VZ); acc(0, 1, 1, VPV);

      // eight zeros: B00V twice with alternating polarity
      row(0, 1, 0, 0, 1, Z0);
      for (int i = 0; i < 4; i++) acc(0, 0, 1, Z0);
      acc(0, 0, 1, VPB); acc(0, 0, 1, VZ); acc(0, 0, 1, VZ); acc(0, 0, 1, VPV);
      acc(0, 0, 1, VNB); acc(0, 0, 1, VZ); acc(0, 0, 1, VZ); acc(0, 0, 1, VNV);

      // AMI: 1,1,0,0,0,0,1 plus zero flush, no substitution
      row(0, 1, 0, 0, 0, Z0);
      acc(0, 1, 0, Z0); acc(0, 1, 0, Z0); acc(0, 0, 0, Z0); acc(0, 0, 0, Z0);
      acc(0, 0, 0, VPM); acc(0, 0, 0, VNM); acc(0, 1, 0, VZ); acc(0, 0, 0, VZ);
      acc(0, 0, 0, VZ); acc(0, 0, 0, VZ); acc(0, 0, 0, VPM);

      // in_valid gaps with a full pipeline hold the outputs
      row(0, 1, 0, 0, 1, Z0);
      for (int i = 0; i < 4; i++) acc(0, 1, 1, Z0);
      acc(0, 1, 1, VPM);
      row(0, 0, 0, 0, 1, HPM); row(0, 0, 0, 0, 1, HPM);
      acc(0, 1, 1, VNM);
      row(0, 0, 0, 0, 1, HNM);

      // reset mid-stream discards buffered symbols and restarts the fill
      row(0, 1, 0, 0, 1, Z0);
      acc(0, 1, 1, Z0); acc(0, 0, 1, Z0); acc(0, 1, 1, Z0); acc(0, 1, 1, Z0);
      acc(0, 0, 1, VPM); acc(0, 1, 1, VZ);
      row(0, 1, 0, 0, 1, Z0);
      for (int i = 0; i < 4; i++) acc(0, 0, 1, Z0);
      acc(0, 0, 1, VPB); acc(0, 0, 1, VZ); acc(0, 0, 1, VZ); acc(0, 0, 1, VPV);

      // ZRUN=3: 1,000 gives 00V
      row(1, 1, 0, 0, 1, Z0);
      acc(1, 1, 1, Z0); acc(1, 0, 1, Z0); acc(1, 0, 1, Z0);
      acc(1, 0, 1, VPM); acc(1, 1, 1, VZ); acc(1, 1, 1, VZ); acc(1, 1, 1, VPV);

      for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

      run_stream(1'b0, 3000, 1'b1, 4, "rand4");
      run_stream(1'b1, 10000, 1'b0, 3, "rand3");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hdbn_line_encoder.md
HDBN_LINE_ENCODER -- requirements
Module: hdbn_line_encoder

Interface
REQ-001 SHALL have parameter ZRUN, default 4, meaning the zero-run length that triggers substitution; legal range 2..8.
REQ-002 SHALL have parameter DEF_MODE, default 1, meaning the mode after reset: 0 = AMI, 1 = HDBn.
REQ-003 SHALL have port clk, input, 1, the clock.
REQ-004 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning in_bit is accepted this cycle.
REQ-006 SHALL have port in_bit, input, 1, the NRZ data bit.
REQ-007 SHALL have port mode, input, 1: 0 = AMI, 1 = HDBn; it is sampled per accepted bit.
REQ-008 SHALL have port out_valid, output, 1, a one-cycle strobe marking a new output symbol.
REQ-009 SHALL have ports out_p and out_n, output, 1 each, carrying dual-rail ternary: 10 = +, 01 = −, 00 = 0.
REQ-010 SHALL have port out_code, output, 2, the symbol type: 00 zero, 01 mark, 10 B, 11 V.

Function
REQ-011 SHALL hold accepted symbols in a ZRUN-deep delay line that advances only on in_valid=1.
REQ-012 SHALL keep an input-side zero-run counter, width clog2(ZRUN+1): a 1 clears it, a 0 increments it.
REQ-013 In HDBn mode, when the counter would reach ZRUN, the block SHALL rewrite the run in place.
- If the parity is even, the run becomes B, 0.., V.
- If the parity is odd, the run becomes 0.., V.
- The counter SHALL then clear.
REQ-014 Parity SHALL be an input-side count, mod 2, of marks and B symbols entering since the last V; entering V SHALL clear it.
REQ-015 In AMI mode, no substitution SHALL occur; zeros pass through as zeros.
REQ-016 The output stage SHALL hold last_pol, meaning the polarity of the last non-zero pulse.
- A mark or B SHALL emit the opposite of last_pol and update last_pol.
- V SHALL emit a pulse equal to last_pol and leave last_pol unchanged.
- A zero SHALL emit 00.
REQ-017 Latency: the symbol for accepted bit k SHALL be registered on the clock edge that accepts bit k+ZRUN.
- out_valid SHALL be high for that one cycle.
REQ-018 out_valid SHALL stay 0 until ZRUN bits have been accepted since reset; a fill counter saturates at ZRUN.
REQ-019 When in_valid=0, out_valid SHALL be 0 and out_p, out_n and out_code SHALL hold their values.
REQ-020 out_p and out_n SHALL never both be 1.
REQ-021 A mode change SHALL affect only bits accepted afterwards; symbols already in the delay line SHALL be emitted unchanged.
- The zero-run counter SHALL clear on any mode change.

Reset
REQ-022 On reset_n=0, the block SHALL force the following, asynchronously:
- out_valid=0, out_p=0, out_n=0, out_code=00;
- delay line all zero;
- zero-run, fill and parity counters = 0;
- last_pol = negative, so the first pulse is +.
REQ-023 A reset mid-stream SHALL discard all buffered symbols; the first bit accepted after release restarts the fill.

Structure
REQ-024 Package hdbn_pkg SHALL hold:
- the symbol typedef {ZERO=2'b00, MARK=2'b01, BPULSE=2'b10, VPULSE=2'b11};
- the dual-rail constants.
REQ-025 Polarity assignment SHALL live in one sub-module, hdbn_polar_stage, which takes the symbol type and produces out_p, out_n and out_code.

Verification
REQ-026 ZRUN=4, HDBn: after reset, bits 1,0,0,0,0, then four 1s to flush -> outputs +,0,0,0,+ (000V, because parity is odd).
REQ-027 ZRUN=4, HDBn: bits 0×8, then 0×4 to flush -> +,0,0,+,−,0,0,− (B00V twice, out_code 10,00,00,11 repeated).
REQ-028 ZRUN=4, AMI: bits 1,1,0,0,0,0,1, then flush -> +,−,0,0,0,0,+; out_code never 10 or 11.
REQ-029 in_valid toggled 1,0,0,1 with ZRUN=4 and a full pipeline -> out_valid pulses only on accept cycles; out_p, out_n and out_code are held across the gap.
REQ-030 Reset asserted after 6 bits, then bits 0×4 and a flush -> out_valid stays 0 until 4 post-reset accepts; first emitted symbol is B = +.
REQ-031 ZRUN=3, HDBn: bits 1,0,0,0, then flush -> +,0,0,+; a random 10k-bit run shows no four-zero run, no 11 on out_p/out_n, and alternating V polarity.
